// File: rtl/commit_feeder.sv
// commit_feeder: DUT-side end of the ISS lockstep check interface.
// Retired-instruction events from the core are queued in a small FIFO. Each
// queued PC is shown to the ISS checker for one cycle. The checker's
// miss/next_pc/next_insn answer is taken one cycle later. The block counts
// checks and mismatches, keeps the first and last failing PC, and stops
// accepting commits once the mismatch threshold is reached.
//
// Handshake: the core transfers an entry on a rising edge where
// commit_valid & commit_ready are both high. commit_valid may be raised at
// any time. commit_ready depends only on registered state (FIFO not full and
// not halted), so it never combinationally follows commit_valid.
module commit_feeder #(
  parameter int unsigned DEPTH    = 8,
  parameter logic [63:0] IDLE_PC  = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter int unsigned MAX_MISS = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        commit_valid,
  input  logic [63:0] commit_pc,
  input  logic [31:0] commit_insn,
  output logic        commit_ready,
  output logic [63:0] next_pc_check,
  input  logic [63:0] next_pc,
  input  logic [31:0] next_insn,
  input  logic        miss,
  output logic [31:0] checked_count,
  output logic [15:0] miss_count,
  output logic        mismatch,
  output logic        halt,
  output logic [63:0] first_bad_pc,
  output logic [63:0] last_bad_pc,
  // FSM state for observation: 0 IDLE, 1 PRESENT, 2 AWAIT, 3 HALT
  output logic [1:0]  dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESENT = 2'd1,
    S_AWAIT   = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [63:0] pc_mem   [DEPTH];
  logic [31:0] insn_mem [DEPTH];

  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count;
  logic          full, empty, push, pop;
  logic [AW-1:0] head_idx, next_idx;
  logic [63:0]   head_pc;
  logic [31:0]   head_insn;

  logic [63:0] npc_q, npc_d;
  logic [31:0] checked_q, checked_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;
  logic        mismatch_q, mismatch_d;
  logic [63:0] first_q, first_d, last_q, last_d;
  logic [63:0] exp_pc_q, exp_pc_d;
  logic [31:0] exp_insn_q, exp_insn_d;
  logic        exp_valid_q, exp_valid_d;
  logic        pc_err, insn_err;

  // Extra pointer bit distinguishes full from empty
  assign count     = wr_ptr_q - rd_ptr_q;
  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign head_idx  = rd_ptr_q[AW-1:0];
  assign next_idx  = head_idx + AW'(1);
  assign head_pc   = pc_mem[head_idx];
  assign head_insn = insn_mem[head_idx];

  assign commit_ready = !full && (state_q != S_HALT);
  assign push         = commit_valid && commit_ready;
  assign pop          = (state_q == S_AWAIT);

  assign next_pc_check = npc_q;
  assign checked_count = checked_q;
  assign miss_count    = miss_cnt_q;
  assign mismatch      = mismatch_q;
  assign halt          = (state_q == S_HALT);
  assign first_bad_pc  = first_q;
  assign last_bad_pc   = last_q;
  assign dbg_state     = state_q;

  // Instruction mismatch only counts when the checker's prediction refers to this PC
  assign pc_err   = miss;
  assign insn_err = !miss && exp_valid_q && (head_pc == exp_pc_q) &&
                    (head_insn != exp_insn_q);

  // FIFO storage write; contents need no reset because pointers gate them
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q[AW-1:0]]   <= commit_pc;
      insn_mem[wr_ptr_q[AW-1:0]] <= commit_insn;
    end
  end

  // Next-state and output logic for the present/await sequencer
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    npc_d       = IDLE_PC;
    checked_d   = checked_q;
    miss_cnt_d  = miss_cnt_q;
    mismatch_d  = 1'b0;
    first_d     = first_q;
    last_d      = last_q;
    exp_pc_d    = exp_pc_q;
    exp_insn_d  = exp_insn_q;
    exp_valid_d = exp_valid_q;

    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          npc_d   = head_pc;
          state_d = S_PRESENT;
        end
      end
      S_PRESENT: begin
        state_d = S_AWAIT;
      end
      S_AWAIT: begin
        if (checked_q != '1) checked_d = checked_q + 32'd1;
        if (!miss) begin
          exp_pc_d    = next_pc;
          exp_insn_d  = next_insn;
          exp_valid_d = 1'b1;
        end
        if (pc_err || insn_err) begin
          if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 16'd1;
          mismatch_d = 1'b1;
          last_d     = head_pc;
          if (miss_cnt_q == '0) first_d = head_pc;
          if (miss) exp_valid_d = 1'b0;
        end
        // Only entries already stored count; a same-edge push is seen from IDLE
        if ((MAX_MISS != 0) && ({16'd0, miss_cnt_d} >= MAX_MISS)) begin
          state_d = S_HALT;
        end else if (count > PTR_ONE) begin
          npc_d   = pc_mem[next_idx];
          state_d = S_PRESENT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, pointers, counters and capture registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      npc_q       <= IDLE_PC;
      checked_q   <= '0;
      miss_cnt_q  <= '0;
      mismatch_q  <= 1'b0;
      first_q     <= '0;
      last_q      <= '0;
      exp_pc_q    <= '0;
      exp_insn_q  <= '0;
      exp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      npc_q       <= npc_d;
      checked_q   <= checked_d;
      miss_cnt_q  <= miss_cnt_d;
      mismatch_q  <= mismatch_d;
      first_q     <= first_d;
      last_q      <= last_d;
      exp_pc_q    <= exp_pc_d;
      exp_insn_q  <= exp_insn_d;
      exp_valid_q <= exp_valid_d;
    end
  end

endmodule

// File: tb/tb_commit_feeder.sv
// tb_commit_feeder: drives commit_feeder with directed and random commit
// streams, plays the ISS checker, and compares every cycle against a
// transaction-level model of the check sequence.
module tb_commit_feeder;

  localparam int unsigned DEPTH    = 8;
  localparam logic [63:0] IDLE_PC  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam int unsigned MAX_MISS = 2;

  logic        clk;
  logic        rst_n;
  logic        commit_valid;
  logic [63:0] commit_pc;
  logic [31:0] commit_insn;
  logic        commit_ready;
  logic [63:0] next_pc_check;
  logic [63:0] next_pc;
  logic [31:0] next_insn;
  logic        miss;
  logic [31:0] checked_count;
  logic [15:0] miss_count;
  logic        mismatch;
  logic        halt;
  logic [63:0] first_bad_pc;
  logic [63:0] last_bad_pc;
  logic [1:0]  dbg_state;

  commit_feeder #(.DEPTH(DEPTH), .IDLE_PC(IDLE_PC), .MAX_MISS(MAX_MISS)) dut (
    .clk(clk), .rst_n(rst_n),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_insn(commit_insn),
    .commit_ready(commit_ready), .next_pc_check(next_pc_check),
    .next_pc(next_pc), .next_insn(next_insn), .miss(miss),
    .checked_count(checked_count), .miss_count(miss_count), .mismatch(mismatch),
    .halt(halt), .first_bad_pc(first_bad_pc), .last_bad_pc(last_bad_pc),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic [63:0] pc; logic [31:0] insn; } entry_t;
  typedef struct { logic miss; logic [63:0] np; logic [31:0] ni; } resp_t;

  entry_t      exp_q[$];        // entries accepted and not yet checked, in order
  resp_t       resp_q[$];       // directed checker answers, used before random ones
  bit          hit_all = 0;     // checker always answers "hit" with a harmless prediction
  bit          chk_en = 0;
  logic        pend = 0;        // a PC was sampled; its answer is due at the next edge
  logic        r_miss;
  logic [63:0] r_np;
  logic [31:0] r_ni;
  logic [31:0] m_checked;
  logic [15:0] m_miss;
  logic [63:0] m_first, m_last, m_epc;
  logic [31:0] m_einsn;
  logic        m_ev, m_halt, exp_mm;
  int          cyc = 0;
  int          last_sample_cyc = -100;
  int          gap2_cnt = 0;
  int          bp_low = 0;
  int          stall_cnt = 0;

  // Model of one check: ordered pop, error rules, counters, threshold
  always @(posedge clk) begin
    entry_t e;
    resp_t  r;
    logic   had_pend, pc_err, insn_err;
    cyc++;
    exp_mm = 1'b0;
    if (!rst_n) begin
      exp_q.delete();
      pend = 0; m_checked = '0; m_miss = '0; m_first = '0; m_last = '0;
      m_epc = '0; m_einsn = '0; m_ev = 0; m_halt = 0; chk_en = 1;
    end else if (chk_en) begin
      had_pend = pend;
      if (pend) begin
        e = exp_q.pop_front();
        if (m_checked != 32'hFFFF_FFFF) m_checked = m_checked + 1;
        pc_err   = r_miss;
        insn_err = !r_miss && m_ev && (e.pc == m_epc) && (e.insn != m_einsn);
        if (!r_miss) begin m_epc = r_np; m_einsn = r_ni; m_ev = 1; end
        if (pc_err || insn_err) begin
          if (m_miss == 0) m_first = e.pc;
          if (m_miss != 16'hFFFF) m_miss = m_miss + 1;
          m_last = e.pc;
          exp_mm = 1'b1;
          if (r_miss) m_ev = 0;
        end
        if (MAX_MISS != 0 && m_miss >= MAX_MISS) m_halt = 1;
        pend = 0;
      end
      if (next_pc_check != IDLE_PC) begin
        check_val("present_once", had_pend, 0);
        check_val("present_pc", next_pc_check, (exp_q.size() > 0) ? exp_q[0].pc : IDLE_PC);
        if (cyc - last_sample_cyc == 2) gap2_cnt++;
        last_sample_cyc = cyc;
        if (resp_q.size() > 0) begin
          r = resp_q.pop_front();
        end else if (hit_all) begin
          r = '{1'b0, 64'h0, 32'h0};
        end else begin
          r.miss = ($urandom_range(0, 9) == 0);
          r.np   = ($urandom_range(0, 3) != 0) ? next_pc_check + 64'd4 : next_pc_check + 64'd8;
          r.ni   = ($urandom_range(0, 3) == 0) ? 32'h0000_0297 : 32'h0000_0013;
        end
        r_miss = r.miss; r_np = r.np; r_ni = r.ni;
        pend = 1;
      end
      if (commit_valid && commit_ready) exp_q.push_back({commit_pc, commit_insn});
    end
  end

  // Scoreboard: observable outputs against the model every cycle
  always @(negedge clk) begin
    if (chk_en) begin
      check_val("checked_count", checked_count, m_checked);
      check_val("miss_count", miss_count, m_miss);
      check_val("mismatch", mismatch, exp_mm);
      check_val("halt", halt, m_halt);
      check_val("first_bad_pc", first_bad_pc, m_first);
      check_val("last_bad_pc", last_bad_pc, m_last);
      check_val("commit_ready", commit_ready, (exp_q.size() < DEPTH) && !m_halt);
      if (m_halt) check_val("halt_idle_pc", next_pc_check, IDLE_PC);
      if (!commit_ready && !m_halt) bp_low++;
      if (exp_q.size() > 0 && !m_halt && !pend) stall_cnt++;
      else stall_cnt = 0;
      check_val("no_stall", stall_cnt <= 4, 1);
    end
  end

  // ISS checker: answers during the cycle after it samples; junk otherwise
  initial begin
    miss = 0; next_pc = '0; next_insn = '0;
    forever begin
      @(negedge clk);
      if (pend) begin
        miss = r_miss; next_pc = r_np; next_insn = r_ni;
      end else begin
        miss      = 1'($urandom_range(0, 1));
        next_pc   = {32'h8000_0000, 32'($urandom)};
        next_insn = 32'($urandom);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_one(input logic [63:0] pc, input logic [31:0] insn);
    int n = 0;
    @(negedge clk);
    commit_valid = 1; commit_pc = pc; commit_insn = insn;
    while (!commit_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_val("push_accepted", commit_ready, 1);
  endtask

  task automatic drop_valid();
    @(negedge clk);
    commit_valid = 0;
  endtask

  task automatic do_reset(input int cycles, input logic valid);
    @(negedge clk);
    rst_n = 0; commit_valid = valid;
    repeat (cycles) @(negedge clk);
    rst_n = 1; commit_valid = 0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || pend) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_val("drain_done", n < 200, 1);
    repeat (2) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt, n, g0, b0;
    logic [63:0] pc;
    logic        acc;
    rst_n = 0; commit_valid = 1; commit_pc = 64'h1234; commit_insn = 32'h13;

    // Reset held 3 cycles with commit_valid high
    repeat (3) @(negedge clk);
    rst_n = 1; commit_valid = 0;
    @(negedge clk);
    check_val("rst_npc", next_pc_check, IDLE_PC);
    check_val("rst_ready", commit_ready, 1);
    check_val("rst_checked", checked_count, 0);
    check_val("rst_miss", miss_count, 0);
    check_val("rst_state", dbg_state, 0);

    // Single hit with known timing
    resp_q.push_back('{1'b0, 64'h8000_0004, 32'h0202_8593});
    push_one(64'h8000_0000, 32'h0000_0297);
    drop_valid();
    check_val("hit_idle_k", next_pc_check, IDLE_PC);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (next_pc_check == 64'h8000_0000) cnt++;
      if (i == 1) check_val("hit_checked_k2", checked_count, 0);
      if (i == 2) check_val("hit_checked_k3", checked_count, 1);
    end
    check_val("hit_present_cycles", cnt, 1);
    check_val("hit_miss", miss_count, 0);

    // Instruction mismatch against the predicted insn
    resp_q.push_back('{1'b0, 64'h8000_0008, 32'h0000_0013});
    push_one(64'h8000_0004, 32'h0000_0013);
    drop_valid();
    wait_drain();
    check_val("insn_miss_count", miss_count, 1);
    check_val("insn_first", first_bad_pc, 64'h8000_0004);
    check_val("insn_last", last_bad_pc, 64'h8000_0004);
    check_val("insn_no_halt", halt, 0);

    // PC miss reaches the threshold
    resp_q.push_back('{1'b1, 64'h0, 32'h0});
    push_one(64'h8000_1000, 32'h0000_0013);
    drop_valid();
    wait_drain();
    check_val("pcmiss_count", miss_count, 2);
    check_val("pcmiss_first", first_bad_pc, 64'h8000_0004);
    check_val("pcmiss_last", last_bad_pc, 64'h8000_1000);
    check_val("pcmiss_halt", halt, 1);
    check_val("pcmiss_ready", commit_ready, 0);
    @(negedge clk);
    commit_valid = 1; commit_pc = 64'h8000_2000;
    repeat (4) @(negedge clk);
    commit_valid = 0;
    check_val("halt_frozen_checked", checked_count, 3);

    // Backpressure: back-to-back pushes fill the FIFO
    do_reset(1, 0);
    hit_all = 1;
    g0 = gap2_cnt; b0 = bp_low;
    for (int i = 0; i < 20; i++) push_one(64'h9000_0000 + 64'(4 * i), 32'h13);
    drop_valid();
    wait_drain();
    hit_all = 0;
    check_val("bp_checked", checked_count, 20);
    check_val("bp_ready_low", bp_low > b0, 1);
    check_val("bp_spacing", gap2_cnt - g0, 19);
    check_val("bp_miss", miss_count, 0);

    // Reset while a check is awaiting its answer
    push_one(64'hA000_0000, 32'h13);
    drop_valid();
    n = 0;
    while (dbg_state != 2'd2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_val("await_reached", dbg_state, 2);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    check_val("midrst_checked", checked_count, 0);
    check_val("midrst_state", dbg_state, 0);
    check_val("midrst_ready", commit_ready, 1);
    repeat (3) @(negedge clk);
    check_val("midrst_empty", next_pc_check, IDLE_PC);

    // Random segments, each started from reset
    for (int s = 0; s < 12; s++) begin
      do_reset(1 + int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      pc = 64'h8000_0000 + 64'({$urandom_range(0, 255), 4'b0});
      acc = 0;
      for (int c = 0; c < 80; c++) begin
        @(negedge clk);
        if (acc) pc = pc + (($urandom_range(0, 7) == 0) ? 64'd8 : 64'd4);
        commit_valid = ($urandom_range(0, 2) != 0);
        commit_pc    = pc;
        commit_insn  = ($urandom_range(0, 3) == 0) ? 32'h0000_0297 : 32'h0000_0013;
        acc = commit_valid && commit_ready;
      end
      commit_valid = 0;
      repeat (30) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/commit_feeder.md
Name: commit_feeder

Overview:
- DUT-side end of the ISS lockstep check interface. It buffers retired-instruction events from the core in a FIFO.
- It presents one retired PC at a time on next_pc_check to the ISS checker and samples the checker's miss/next_pc/next_insn response.
- It counts checks and mismatches, records the first and last failing PC, and halts the commit stream once a mismatch threshold is reached.
- Sits between the core retire port and the checker instance in the simulation top.

Parameters:
- DEPTH, 8, commit FIFO entries; power of 2, ≥2.
- IDLE_PC, 64'hFFFF_FFFF_FFFF_FFFF, value driven on next_pc_check when no candidate is presented; must never equal a legal PC.
- MAX_MISS, 1, mismatch count that forces HALT; 0 means never halt.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- commit_valid  in  1  core retires an instruction this cycle
- commit_pc  in  64  retired PC
- commit_insn  in  32  retired instruction word
- commit_ready  out  1  FIFO can accept; transfer = commit_valid & commit_ready
- next_pc_check  out  64  candidate PC to checker, registered
- next_pc  in  64  checker's expected next PC, valid one cycle after its sample edge
- next_insn  in  32  checker's expected next instruction word
- miss  in  1  checker result for the PC sampled at the previous edge
- checked_count  out  32  entries checked, saturating
- miss_count  out  16  mismatches (PC or insn), saturating
- mismatch  out  1  one-cycle pulse per mismatch
- halt  out  1  sticky; threshold reached
- first_bad_pc  out  64  PC of first mismatch
- last_bad_pc  out  64  PC of most recent mismatch

Behaviour:
- Reset (rst_n=0 at posedge):
  - FIFO flushed; state IDLE; exp_valid=0.
  - next_pc_check=IDLE_PC; counters, first_bad_pc and last_bad_pc = 0.
  - mismatch=0, halt=0; commit_ready=1 from the first cycle after reset.
  - Reset mid-operation discards the in-flight check without counting it. The checker is not reset.
- FIFO:
  - commit_ready = !full & !halt (combinational from registered state).
  - Push and pop in the same cycle are legal when not full. Pointers wrap modulo DEPTH.
  - A push into an empty FIFO is visible to the FSM the following cycle.
- FSM states: IDLE, PRESENT, AWAIT, HALT.
- IDLE:
  - next_pc_check=IDLE_PC.
  - If FIFO non-empty: load next_pc_check=head.pc, go PRESENT.
- PRESENT (one cycle):
  - The checker samples next_pc_check at the closing edge.
  - At that edge: next_pc_check←IDLE_PC, go AWAIT.
- AWAIT (one cycle):
  - At the closing edge, sample miss/next_pc/next_insn; this is the result for head.pc.
  - PC error = miss.
  - Insn error = !miss & exp_valid & (head.pc==exp_pc) & (head.insn!=exp_insn).
  - On !miss: exp_pc←next_pc, exp_insn←next_insn, exp_valid←1.
  - Always pop head and increment checked_count.
  - On either error:
    - miss_count+1; mismatch=1 for one cycle; last_bad_pc←head.pc.
    - first_bad_pc←head.pc only if miss_count was 0.
    - On miss, exp_valid←0.
  - Next state:
    - If MAX_MISS≠0 and the updated miss_count ≥ MAX_MISS: HALT.
    - Else if FIFO non-empty after the pop: load next head, go PRESENT.
    - Else: IDLE.
- HALT:
  - halt=1, commit_ready=0, next_pc_check=IDLE_PC.
  - Stays in HALT until reset; remaining FIFO contents are frozen.
- Latency and throughput:
  - Entry pushed at edge k is presented during cycle k+1→k+2.
  - Counters and mismatch update at edge k+3.
  - Steady-state throughput is one check per 2 cycles.
- The miss value the checker returns for an IDLE_PC sample is ignored; miss is used only in AWAIT.
- Counters saturate at all-ones.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with commit_valid=1 -> next_pc_check=IDLE_PC, commit_ready=1 after release, all counts 0, FIFO empty.
- Single hit: push pc=0x80000000, insn=0x00000297; checker model returns miss=0, next_pc=0x80000004, next_insn=0x02028593 -> next_pc_check=0x80000000 during exactly one cycle; checked_count=1 three edges after the push; miss_count=0.
- Insn mismatch: after the above, push pc=0x80000004, insn=0x00000013; model returns miss=0 -> miss_count=1, mismatch one-cycle pulse, first_bad_pc=last_bad_pc=0x80000004, halt=1 (MAX_MISS=1), commit_ready=0.
- PC miss with MAX_MISS=0: push 0x80000000 then 0x80001000; model misses the second -> miss_count=1, halt=0, checking continues.
- Backpressure: DEPTH=8; push 10 back-to-back entries with the model always hitting -> commit_ready deasserts when the FIFO is full; all 10 are eventually checked in order; checked_count=10; next_pc_check shows entries in push order, 2 cycles apart.
- Reset mid-check: assert rst_n=0 in AWAIT -> no count increment, FIFO empty, state IDLE.
